keypad_uart_sender: RTL and testbench

//  Downstream consumer of the keypad scanner's 5-bit decoded output. Converts each

---
 rtl/keypad_uart_sender.sv | 195 +++++++++++++++++++
 tb/tb_keypad_uart_sender.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_uart_sender.sv
// Debounces the keypad scanner code, turns each new key press into ASCII, queues it,
// and sends it out as a UART frame. Build with PARITY_EN defined for 8E1, otherwise 8N1.
module keypad_uart_sender #(
  parameter int CLK_HZ       = 48000000,
  parameter int BAUD         = 9600,
  parameter int DEBOUNCE_CYC = 48000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_code,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST      = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  function automatic logic [7:0] to_ascii(input logic [3:0] hex);
    if (hex < 4'd10) to_ascii = 8'h30 + {4'h0, hex};
    else             to_ascii = 8'h37 + {4'h0, hex};
  endfunction

  logic [4:0]       sync_a;
  logic [4:0]       sync_b;
  logic [4:0]       cand;
  logic [4:0]       stable;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;
  logic             push;
  logic [7:0]       push_char;

  // A press is a new valid key, or a direct change from one valid key to another.
  assign press = cand[4] && (!stable[4] || (stable[3:0] != cand[3:0]));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a    <= '0;
      sync_b    <= '0;
      cand      <= '0;
      stable    <= '0;
      deb_cnt   <= '0;
      push      <= 1'b0;
      push_char <= '0;
    end else begin
      sync_a <= key_code;
      sync_b <= sync_a;
      push   <= 1'b0;
      if (sync_b != cand) begin
        cand    <= sync_b;
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_LAST) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end else if (cand != stable) begin
        stable    <= cand;
        push      <= press;
        push_char <= to_ascii(cand[3:0]);
      end
    end
  end

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;

  assign fifo_full  = (count == FIFO_FULL_CNT);
  assign fifo_empty = (count == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  state_t            state;
  state_t            state_n;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              baud_done;
`ifdef PARITY_EN
  logic              parity;
`endif

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (baud_done) state_n = S_DATA;
      end
      S_DATA: begin
        tx = shift[0];
        if (baud_done && bit_cnt == 3'd7) begin
`ifdef PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        tx = parity;
        if (baud_done) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Every state change happens on a bit boundary or out of IDLE, so clearing the
  // baud counter there restarts it on each state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == S_IDLE || baud_done) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + BAUD_W'(1);
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_cnt <= '0;
`ifdef PARITY_EN
        parity  <= ^mem[rd_ptr];
`endif
      end else if (state == S_DATA && baud_done) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_uart_sender.sv
// Directed bench for keypad_uart_sender: debounce, press detection, FIFO overflow,
// back-to-back framing and mid-frame reset, with an independent UART line monitor.
module tb_keypad_uart_sender;

`ifdef PARITY_EN
  localparam int FRAME = 176;
`else
  localparam int FRAME = 160;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ok;
    logic       par;
    int         start;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] key_code;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     busy_run = 0;
  int     busy_len = 0;
  int     frame_starts = 0;
  int     snap;
  int     starts [5];
  frame_t rx_q [$];

  logic [7:0] mon_data;
  logic       mon_st;
  logic       mon_sp;
  logic       mon_par;
  int         mon_start;

  keypad_uart_sender #(
    .CLK_HZ      (1600),
    .BAUD        (100),
    .DEBOUNCE_CYC(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_code (key_code),
    .tx       (tx),
    .busy     (busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Busy pulse length and count of frames started.
  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) begin
      if (busy_run == 0) frame_starts++;
      busy_run++;
    end else begin
      if (busy_run != 0) busy_len = busy_run;
      busy_run = 0;
    end
  end

  // UART line monitor sampling mid-bit, 16 cycles per bit.
  initial forever begin
    @(negedge clk);
    if (tx === 1'b0) begin
      mon_start = cyc;
      repeat (8) @(negedge clk);
      mon_st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        mon_data[i] = tx;
      end
`ifdef PARITY_EN
      repeat (16) @(negedge clk);
      mon_par = tx;
`else
      mon_par = 1'b0;
`endif
      repeat (16) @(negedge clk);
      mon_sp = tx;
      rx_q.push_back('{data: mon_data, ok: (mon_st === 1'b0 && mon_sp === 1'b1),
                       par: mon_par, start: mon_start});
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] code, input int cycles);
    key_code = code;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitFrames(input int n, input int budget);
    int b = 0;
    while (rx_q.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic expectFrame(input string tag, input logic [7:0] exp, output int start);
    frame_t f;
    start = 0;
    if (rx_q.size() == 0) begin
      checkOutput({tag, " present"}, 32'(rx_q.size()), 32'd1);
      return;
    end
    f = rx_q.pop_front();
    start = f.start;
    checkOutput({tag, " data"}, {24'h0, f.data}, {24'h0, exp});
    checkOutput({tag, " framing"}, {31'h0, f.ok}, 32'd1);
`ifdef PARITY_EN
    checkOutput({tag, " parity"}, {31'h0, f.par}, {31'h0, ^exp});
`endif
  endtask

  initial begin
    int s;
    rst      = 1'b1;
    key_code = 5'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset tx", {31'h0, tx}, 32'd1);
    checkOutput("reset busy", {31'h0, busy}, 32'd0);
    checkOutput("reset fifo_full", {31'h0, fifo_full}, 32'd0);
    checkOutput("reset overflow", {31'h0, overflow}, 32'd0);
    rst = 1'b0;

    $display("[TB] test 1: single press 5'h17");
    applyStimulus(5'h17, 8);
    checkOutput("t1 tx before start", {31'h0, tx}, 32'd1);
    applyStimulus(5'h17, 1);
    checkOutput("t1 tx start edge", {31'h0, tx}, 32'd0);
    checkOutput("t1 busy at start", {31'h0, busy}, 32'd1);
    applyStimulus(5'h17, 11);
    key_code = 5'h00;
    waitFrames(1, 400);
    repeat (30) @(negedge clk);
    checkOutput("t1 frame count", 32'(rx_q.size()), 32'd1);
    expectFrame("t1 frame", 8'h37, s);
    checkOutput("t1 busy length", 32'(busy_len), 32'(FRAME));

    $display("[TB] test 2: bouncing 5'h1A");
    snap = frame_starts;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'h1A, 2);
      applyStimulus(5'h00, 2);
    end
    applyStimulus(5'h00, 40);
    checkOutput("t2 no frame on bounce", 32'(frame_starts), 32'(snap));
    key_code = 5'h1A;
    waitFrames(1, 400);
    applyStimulus(5'h00, 30);
    checkOutput("t2 frame count", 32'(rx_q.size()), 32'd1);
    expectFrame("t2 frame", 8'h41, s);

    $display("[TB] test 3: hold, re-press, direct change");
    applyStimulus(5'h15, 200);
    applyStimulus(5'h00, 20);
    applyStimulus(5'h15, 200);
    applyStimulus(5'h19, 200);
    applyStimulus(5'h00, 20);
    checkOutput("t3 frame count", 32'(rx_q.size()), 32'd3);
    expectFrame("t3 first", 8'h35, s);
    expectFrame("t3 repress", 8'h35, s);
    expectFrame("t3 change", 8'h39, s);

    $display("[TB] test 4: six presses during one frame");
    applyStimulus(5'h11, 8);
    applyStimulus(5'h12, 8);
    applyStimulus(5'h13, 8);
    applyStimulus(5'h14, 8);
    applyStimulus(5'h16, 8);
    applyStimulus(5'h18, 8);
    applyStimulus(5'h00, 10);
    checkOutput("t4 fifo_full", {31'h0, fifo_full}, 32'd1);
    checkOutput("t4 overflow", {31'h0, overflow}, 32'd1);
    waitFrames(5, 1200);
    repeat (300) @(negedge clk);
    checkOutput("t4 frame count", 32'(rx_q.size()), 32'd5);
    expectFrame("t4 f0", 8'h31, starts[0]);
    expectFrame("t4 f1", 8'h32, starts[1]);
    expectFrame("t4 f2", 8'h33, starts[2]);
    expectFrame("t4 f3", 8'h34, starts[3]);
    expectFrame("t4 f4", 8'h36, starts[4]);
    for (int i = 0; i < 4; i++)
      checkOutput("t4 frame spacing", 32'(starts[i+1] - starts[i]), 32'(FRAME + 1));
    checkOutput("t4 overflow sticky", {31'h0, overflow}, 32'd1);
    checkOutput("t4 fifo drained", {31'h0, fifo_full}, 32'd0);

    $display("[TB] test 5: reset during data bit 3");
    applyStimulus(5'h17, 9);
    checkOutput("t5 start", {31'h0, tx}, 32'd0);
    applyStimulus(5'h12, 68);
    checkOutput("t5 busy before reset", {31'h0, busy}, 32'd1);
    rst      = 1'b1;
    key_code = 5'h00;
    @(negedge clk);
    checkOutput("t5 tx after reset", {31'h0, tx}, 32'd1);
    checkOutput("t5 busy after reset", {31'h0, busy}, 32'd0);
    checkOutput("t5 overflow cleared", {31'h0, overflow}, 32'd0);
    checkOutput("t5 fifo_full cleared", {31'h0, fifo_full}, 32'd0);
    rst  = 1'b0;
    snap = frame_starts;
    repeat (200) @(negedge clk);
    checkOutput("t5 fifo emptied", 32'(frame_starts), 32'(snap));
    rx_q.delete();

    $display("[TB] test 6: key 5'h13");
    applyStimulus(5'h13, 20);
    key_code = 5'h00;
    waitFrames(1, 400);
    repeat (30) @(negedge clk);
    expectFrame("t6 frame", 8'h33, s);
    checkOutput("t6 busy length", 32'(busy_len), 32'(FRAME));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
